fb_write_arbiter: RTL
=====================

Name: fb_write_arbiter

Overview:
- Merges two 54-bit pixel-write streams into the single frame-buffer write port: source 0 is the base-image writer, source 1 is the overlay drawer.
- Fixed priority to the overlay, with starvation protection for the image path.
- One registered output stage, so the frame buffer sees stable, registered write requests under valid/ready backpressure.

Parameters:
- ADDR_W, 17, word address width of the frame buffer.
- DATA_W, 32, pixel word width (four 8-bit pixels).
- MASK_W, 4, byte write-mask width.
- STARVE_MAX, 16, consecutive source-0 losses before source 0 is forced a grant (range 1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- s0_din  in  54  image write beat {mask[53:50], frame[49], addr[48:32], pixel[31:0]}
- s0_valid  in  1  source 0 beat valid
- s0_ready  out  1  source 0 beat accepted this cycle when high with s0_valid
- s1_din  in  54  overlay write beat, same packing
- s1_valid  in  1  source 1 beat valid
- s1_ready  out  1  source 1 accept
- wr_addr  out  ADDR_W  frame-buffer word address
- wr_data  out  DATA_W  pixel word
- wr_mask  out  MASK_W  byte-enable mask
- wr_frame  out  1  target frame-buffer select
- wr_valid  out  1  write request valid
- wr_ready  in  1  frame buffer accepts request
- grant_src  out  1  source of the beat currently held on wr_* (0 or 1)

Behaviour:
- Reset (reset==0 at posedge) forces:
  - wr_valid=0, grant_src=0.
  - wr_addr/wr_data/wr_mask/wr_frame = 0.
  - Starvation counter = 0.
  - Any held beat is dropped.
- Reset can be asserted mid-transfer; no partial beat survives it.
- Output stage has two states: EMPTY (wr_valid=0) and FULL (wr_valid=1).
- load = !wr_valid | wr_ready, evaluated combinationally.
- Grant is combinational, made each cycle only when load==1:
  - If only one source is valid, grant it.
  - If both are valid, grant s1, unless starve_cnt==STARVE_MAX, in which case grant s0.
- sN_ready = load & grant==N. The non-granted source's ready is 0. Ready never depends on the other source's ready.
- On load with a granted valid source:
  - Register that source's fields into wr_*.
  - Set grant_src and wr_valid=1.
- On load with no valid source: wr_valid=0.
- Latency: beat accepted at edge k appears on wr_* after edge k. One beat per cycle is sustained when wr_ready=1.
- Simultaneous drain and refill in the same cycle is required; there must be no bubble.
- While FULL and wr_ready==0:
  - All wr_* outputs and grant_src stay stable.
  - Both readies are 0.
- Starvation counter is 8-bit:
  - Increments when both sources are valid, load==1 and s1 is granted.
  - Clears to 0 on any s0 grant.
  - Holds otherwise.
  - Never exceeds STARVE_MAX.
- Fields pass through unmodified. Address, mask and frame are not checked; out-of-range addresses are the producer's responsibility.

Optional Feature:
- Macro: FB_WRITE_ARBITER_STATS_EN.
- Defined:
  - Adds outputs s0_grants[15:0], s1_grants[15:0] and starve_events[15:0].
  - Counters increment on each accepted beat per source, and on each forced s0 grant.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined:
  - These ports and counters do not exist.
  - Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Beat field offsets (MASK_MSB=53, MASK_LSB=50, FRAME_BIT=49, ADDR_MSB=48, ADDR_LSB=32, PIXEL_MSB=31).
  - Beat width 54.
  - Source IDs SRC_IMAGE=0 and SRC_OVERLAY=1.
- These constants are shared with the image writer and the overlay producer.
- One sub-module is natural: fb_beat_reg, the registered output stage with load/hold logic. Arbitration and starvation logic stay in the top module.

Test Plan:
- Reset drop:
  - Stimulus: reset low for 2 cycles while s1_valid=1 and wr_valid=1 with wr_ready=0.
  - Required: wr_valid=0 on the first edge after reset goes low; no beat is emitted for 1 cycle after reset releases with valid low.
- Single source:
  - Stimulus: s0 streams 8 beats with addresses 0..7 and wr_ready=1 throughout.
  - Required: wr_* shows addresses 0..7 on consecutive cycles, each 1 cycle after acceptance, with grant_src=0.
- Priority and starvation:
  - Stimulus: both sources valid continuously, STARVE_MAX=4, wr_ready=1.
  - Required: grant pattern s1,s1,s1,s1,s0 repeating; s0_ready pulses every 5th cycle.
- Backpressure hold:
  - Stimulus: wr_ready=0 for 5 cycles while a beat {mask=4'b0100, frame=1, addr=17'h1F4, pixel=32'h02020202} is held.
  - Required: all wr_* outputs stable, s0_ready=s1_ready=0.
  - Then: wr_ready=1; the next beat loads on the same edge, with no bubble.
- Idle gap:
  - Stimulus: s1 sends 1 beat, both sources idle for 3 cycles, then s0 sends 1 beat.
  - Required: wr_valid high for 1 cycle, low for 3 cycles, then high for 1 cycle; starvation counter remains 0.
- Stats saturation (FB_WRITE_ARBITER_STATS_EN defined):
  - Stimulus: 70000 accepted s1 beats.
  - Required: s1_grants=16'hFFFF and s0_grants=0.

Source files
------------

// File: rtl/fb_write_arbiter_pkg.sv
// fb_write_arbiter_pkg
//   Beat layout and source IDs shared by the frame-buffer write arbiter,
//   the image writer and the overlay producer.
//   Beat packing: {mask[53:50], frame[49], addr[48:32], pixel[31:0]}.
package fb_write_arbiter_pkg;

   localparam int unsigned BEAT_W    = 54;
   localparam int unsigned MASK_MSB  = 53;
   localparam int unsigned MASK_LSB  = 50;
   localparam int unsigned FRAME_BIT = 49;
   localparam int unsigned ADDR_MSB  = 48;
   localparam int unsigned ADDR_LSB  = 32;
   localparam int unsigned PIXEL_MSB = 31;

   localparam logic SRC_IMAGE   = 1'b0;
   localparam logic SRC_OVERLAY = 1'b1;

   typedef logic [BEAT_W-1:0] fb_beat_t;

endpackage

// File: rtl/fb_beat_reg.sv
// fb_beat_reg
//   Registered output stage of the frame-buffer write arbiter. Holds one
//   beat; drains and refills in the same cycle when wr_ready is high.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   beat, beat_valid  granted beat and whether any source offered one
//   beat_src          source ID of the granted beat
//   wr_ready          frame buffer accepts the held request
//   load              stage may take a new beat this cycle
//   wr_addr/wr_data/wr_mask/wr_frame/wr_valid, grant_src  held request
module fb_beat_reg
   import fb_write_arbiter_pkg::*;
#(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32,
   parameter int MASK_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  fb_beat_t          beat,
   input  logic              beat_valid,
   input  logic              beat_src,
   input  logic              wr_ready,
   output logic              load,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [MASK_W-1:0] wr_mask,
   output logic              wr_frame,
   output logic              wr_valid,
   output logic              grant_src
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0] state;

   assign wr_valid = (state == FULL);
   assign load     = (state == EMPTY) | wr_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= EMPTY;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_mask   <= '0;
         wr_frame  <= 1'b0;
         grant_src <= 1'b0;
      end else if (load) begin
         if (beat_valid) begin
            state     <= FULL;
            wr_addr   <= beat[ADDR_LSB +: ADDR_W];
            wr_data   <= beat[PIXEL_MSB-DATA_W+1 +: DATA_W];
            wr_mask   <= beat[MASK_LSB +: MASK_W];
            wr_frame  <= beat[FRAME_BIT];
            grant_src <= beat_src;
         end else begin
            state <= EMPTY;
         end
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Merges the base-image writer (source 0) and the overlay drawer
//   (source 1) onto one registered frame-buffer write port. The overlay
//   wins ties, except that after STARVE_MAX consecutive tie losses the
//   image source is forced a grant.
// Ports:
//   clock, reset               system clock, synchronous active-low reset
//   s0_din/s0_valid/s0_ready   image beat stream
//   s1_din/s1_valid/s1_ready   overlay beat stream
//   wr_addr/wr_data/wr_mask/wr_frame/wr_valid/wr_ready  frame-buffer port
//   grant_src                  source of the beat held on wr_*
// Optional (macro FB_WRITE_ARBITER_STATS_EN):
//   s0_grants, s1_grants, starve_events  saturating 16-bit counters
module fb_write_arbiter
   import fb_write_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 32,
   parameter int MASK_W     = 4,
   parameter int STARVE_MAX = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  fb_beat_t          s0_din,
   input  logic              s0_valid,
   output logic              s0_ready,
   input  fb_beat_t          s1_din,
   input  logic              s1_valid,
   output logic              s1_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [MASK_W-1:0] wr_mask,
   output logic              wr_frame,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              grant_src
`ifdef FB_WRITE_ARBITER_STATS_EN
   ,
   output logic [15:0]       s0_grants,
   output logic [15:0]       s1_grants,
   output logic [15:0]       starve_events
`endif
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic       load;
   logic       forced;
   logic       gnt;
   logic       both;
   logic [7:0] starve_cnt;
   fb_beat_t   beat;

   assign both   = s0_valid & s1_valid;
   assign forced = both & (starve_cnt == STARVE_LIM);
   assign gnt    = (s1_valid & !forced) ? SRC_OVERLAY : SRC_IMAGE;
   assign beat   = (gnt == SRC_OVERLAY) ? s1_din : s0_din;

   // Readies are held low during reset so no producer sees a beat
   // "accepted" that the reset then drops.
   assign s0_ready = reset & load & (gnt == SRC_IMAGE);
   assign s1_ready = reset & load & (gnt == SRC_OVERLAY);

   always_ff @(posedge clock) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (load) begin
         if (s0_valid && gnt == SRC_IMAGE)
            starve_cnt <= '0;
         else if (both)
            starve_cnt <= starve_cnt + 8'd1;
      end
   end

   fb_beat_reg #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .MASK_W(MASK_W)
   ) u_beat_reg (
      .clock     (clock),
      .reset     (reset),
      .beat      (beat),
      .beat_valid(s0_valid | s1_valid),
      .beat_src  (gnt),
      .wr_ready  (wr_ready),
      .load      (load),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_mask   (wr_mask),
      .wr_frame  (wr_frame),
      .wr_valid  (wr_valid),
      .grant_src (grant_src)
   );

`ifdef FB_WRITE_ARBITER_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         s0_grants     <= '0;
         s1_grants     <= '0;
         starve_events <= '0;
      end else begin
         if (s0_valid && s0_ready && s0_grants != '1)
            s0_grants <= s0_grants + 16'd1;
         if (s1_valid && s1_ready && s1_grants != '1)
            s1_grants <= s1_grants + 16'd1;
         if (forced && load && starve_events != '1)
            starve_events <= starve_events + 16'd1;
      end
   end
`endif

endmodule
